// File: rtl/wb_burst_ram_slave_if.sv
// Wishbone B4 slave-port bundle for the burst RAM. Signal names keep the
// slave-side view (_i into the slave, _o out of it) so both modports agree.
interface wb_burst_ram_slave_if #(
  parameter int Dw   = 32,
  parameter int Aw   = 10,
  parameter int SELw = 4,
  parameter int TAGw = 3,
  parameter int CTIw = 3,
  parameter int BTEw = 2
);
  logic [Aw-1:0]   sa_adr_i;
  logic [Dw-1:0]   sa_dat_i;
  logic [SELw-1:0] sa_sel_i;
  logic [TAGw-1:0] sa_tag_i;
  logic            sa_we_i;
  logic            sa_cyc_i;
  logic            sa_stb_i;
  logic [CTIw-1:0] sa_cti_i;
  logic [BTEw-1:0] sa_bte_i;
  logic [Dw-1:0]   sa_dat_o;
  logic            sa_ack_o;
  logic            sa_err_o;
  logic            sa_rty_o;

  // Handshake: a request is cyc & stb. The slave answers with exactly one of
  // ack/err (registered, never both). The master must hold address, data,
  // sel and we stable until it samples ack or err for that beat.
  modport slave (
    input  sa_adr_i, sa_dat_i, sa_sel_i, sa_tag_i, sa_we_i,
    input  sa_cyc_i, sa_stb_i, sa_cti_i, sa_bte_i,
    output sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
  );

  modport master (
    output sa_adr_i, sa_dat_i, sa_sel_i, sa_tag_i, sa_we_i,
    output sa_cyc_i, sa_stb_i, sa_cti_i, sa_bte_i,
    input  sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
  );
endinterface

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B4 single-port RAM slave with classic cycles, incrementing
// linear/wrap bursts, byte-lane writes and registered read data.
// Unsupported cycle types get a one-cycle err response.
module wb_burst_ram_slave #(
  parameter int Dw   = 32,
  parameter int Aw   = 10,
  parameter int SELw = 4,
  parameter int TAGw = 3,
  parameter int CTIw = 3,
  parameter int BTEw = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  wb_burst_ram_slave_if.slave   bus,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_CLASSIC_ACK = 2'd1,
    S_BURST       = 2'd2,
    S_ERR         = 2'd3
  } state_e;

  localparam logic [CTIw-1:0] CTI_CLASSIC = CTIw'(0);
  localparam logic [CTIw-1:0] CTI_INCR    = CTIw'(2);
  localparam logic [CTIw-1:0] CTI_END     = CTIw'(7);

  state_e          state_q, state_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [Dw-1:0]   dat_q, dat_d;
  logic [Aw-1:0]   baddr_q, baddr_d;

  logic [Dw-1:0]   mem_q [2**Aw];

  logic            req;
  logic            wr_en;
  logic [Aw-1:0]   rd_addr;
  logic [Dw-1:0]   wr_word;

  // Tag is carried on the bus but has no meaning for a RAM.
  logic            unused_tag;
  assign unused_tag = ^bus.sa_tag_i;

  // Burst address step: wrap modes only carry within the low k bits.
  function automatic logic [Aw-1:0] next_addr(input logic [Aw-1:0] a,
                                              input logic [BTEw-1:0] bte);
    logic [Aw-1:0] inc;
    logic [Aw-1:0] mask;
    inc = a + Aw'(1);
    case (bte)
      BTEw'(1): mask = Aw'(3);
      BTEw'(2): mask = Aw'(7);
      BTEw'(3): mask = Aw'(15);
      default:  mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  assign req     = bus.sa_cyc_i & bus.sa_stb_i;
  assign wr_en   = ack_q & req & bus.sa_we_i;
  assign rd_addr = (state_q == S_BURST && ack_q) ? baddr_q : bus.sa_adr_i;

  // Next-state and registered-response decode for the access FSM.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    baddr_d = baddr_q;
    if (!bus.sa_cyc_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (bus.sa_cti_i == CTI_CLASSIC || bus.sa_cti_i == CTI_END) begin
              ack_d   = 1'b1;
              state_d = S_CLASSIC_ACK;
            end else if (bus.sa_cti_i == CTI_INCR) begin
              ack_d   = 1'b1;
              baddr_d = next_addr(bus.sa_adr_i, bus.sa_bte_i);
              state_d = S_BURST;
            end else begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          end
        end
        S_CLASSIC_ACK: state_d = S_IDLE;
        S_ERR:         state_d = S_IDLE;
        S_BURST: begin
          if (req && bus.sa_cti_i == CTI_INCR) begin
            ack_d   = 1'b1;
            baddr_d = next_addr(baddr_q, bus.sa_bte_i);
          end else begin
            // End-of-burst beat is acked now; anything else abandons it.
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Merge write lanes so a same-cycle read of the written word sees new data.
  always_comb begin
    wr_word = mem_q[bus.sa_adr_i];
    for (int b = 0; b < SELw; b++) begin
      if (bus.sa_sel_i[b]) wr_word[8*b +: 8] = bus.sa_dat_i[8*b +: 8];
    end
    dat_d = (wr_en && rd_addr == bus.sa_adr_i) ? wr_word : mem_q[rd_addr];
  end

  // RAM array: byte-lane writes on the acked beat, contents not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < SELw; b++) begin
      if (wr_en && bus.sa_sel_i[b]) begin
        mem_q[bus.sa_adr_i][8*b +: 8] <= bus.sa_dat_i[8*b +: 8];
      end
    end
  end

  // Control and response registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      baddr_q <= baddr_d;
    end
  end

  assign bus.sa_dat_o = dat_q;
  assign bus.sa_ack_o = ack_q;
  assign bus.sa_err_o = err_q;
  assign bus.sa_rty_o = 1'b0;
  assign state_o      = state_q;

endmodule
